mem_write_fifo: RTL and testbench

Elastic write buffer between the IO controller's DMA output and the shared feature-map memory write port. Accepts address/data write requests from the DMA at up to one per cycle, holds them in a DEPTH-entry FIFO, and issues them to memory only in cycles where the arbiter grants the port. Supports a drain-and-acknowledge flush, so the controller can declare loading finished only after every word has landed in memory. Supports an abort, driven from the host interrupt path, that discards pending writes.

---
 rtl/mem_write_fifo.sv | 131 +++++++++++++
 tb/tb_mem_write_fifo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_fifo.sv
`default_nettype none
// ============================================================================
// mem_write_fifo : elastic DMA-to-memory write buffer with drain/ack flush
//                  and abort. Rev 1.0
// ============================================================================
module mem_write_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ADDR_W-1:0]      in_addr_i,
  input  logic [DATA_W-1:0]      in_data_i,
  input  logic                   flush_i,
  input  logic                   abort_i,
  input  logic                   mem_grant_i,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   flush_done_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_ACK   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;

  logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
  logic [DATA_W-1:0]   data_mem_q [DEPTH];

  logic                w_push;
  logic                w_pop;

  assign in_ready_o   = (state_q == S_RUN) && (count_q != C_FULL);
  assign w_push       = in_valid_i & in_ready_o & ~abort_i;
  assign w_pop        = mem_grant_i & (count_q != '0) & (state_q != S_ACK) & ~abort_i;

  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign count_o      = count_q;
  assign flush_done_o = (state_q == S_ACK);

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      addr_mem_q[wr_ptr_q] <= in_addr_i;
      data_mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_we_d   = w_pop;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (w_pop) begin
      mem_addr_d = addr_mem_q[rd_ptr_q];
      mem_data_d = data_mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Once the last word sits in the output register it completes this
    // cycle, so an empty FIFO is enough to move on to the acknowledge.
    case (state_q)
      S_RUN:   if (flush_i) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0) state_d = S_ACK;
      S_ACK:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    if (abort_i) begin
      state_d  = S_RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_fifo.sv
`default_nettype none
// ============================================================================
// tb_mem_write_fifo : vector table plus scoreboard bench for mem_write_fifo.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_write_fifo;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              abort = 1'b0;
  logic              mem_grant = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [CNT_W-1:0]  count;
  logic              flush_done;

  mem_write_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_addr_i   (in_addr),
    .in_data_i   (in_data),
    .flush_i     (flush),
    .abort_i     (abort),
    .mem_grant_i (mem_grant),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .count_o     (count),
    .flush_done_o(flush_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wcnt   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic             v;
    logic             g;
    logic             f;
    logic             ab;
    logic [CNT_W-1:0] cnt;
    logic             rdy;
    logic             we;
    logic             fd;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic g, input logic f, input logic ab);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    mem_grant = g;
    flush     = f;
    abort     = ab;
  endtask

  task automatic load(input int n, input logic [ADDR_W-1:0] base);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, ADDR_W'(base + ADDR_W'(k)), DATA_W'(16'h5000 + k), 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("load_count", 32'(count), 32'(n));
  endtask

  // Scoreboard: record accepted pushes, compare every memory write in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (mem_we) begin : wr_chk
        wr_t e;
        wcnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                   mem_addr, mem_data, $time);
        end else begin
          e = sb.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(e.a));
          chk("write_data", 32'(mem_data), 32'(e.d));
        end
      end
      chk("count_bound", 32'(count <= CNT_W'(DEPTH)), 32'd1);
      if (abort) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{a: in_addr, d: in_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int w0;
    int mcnt;
    logic pend;
    logic g;

    //                 v  g  f  ab cnt rdy we fd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};

    // Reset values
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_fd", 32'(flush_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, ADDR_W'(16'h0500 + i), DATA_W'(16'hB000 + i), tbl[i].g, tbl[i].f, tbl[i].ab);
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_fd", i), 32'(flush_done), 32'(tbl[i].fd));
    end

    // Streaming with grant held high
    for (int i = 0; i < 12; i++) begin
      drive(i < 8, ADDR_W'(16'h0100 + i), DATA_W'(16'hA000 + i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("stream_count", 32'(count <= CNT_W'(1)), 32'd1);
      chk("stream_we", 32'(mem_we), 32'(i >= 2 && i < 10));
      if (i < 8) chk("stream_ready", 32'(in_ready), 32'd1);
    end

    // Backpressure to full, then release with in_valid held
    w0 = wcnt;
    j  = 0;
    for (int c = 0; c < 12; c++) begin
      drive(j < 10, ADDR_W'(16'h0200 + j), DATA_W'(16'hC000 + j), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) j++;
    end
    chk("full_accepted", 32'(j), 32'd8);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, ADDR_W'(16'h0200 + j), DATA_W'(16'hC000 + j), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_pop_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 30 && (j < 10 || sb.size() != 0); c++) begin
      drive(j < 10, ADDR_W'(16'h0200 + j), DATA_W'(16'hC000 + j), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) j++;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_accepted", 32'(j), 32'd10);
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_writes", 32'(wcnt - w0), 32'd10);

    // Grant gaps 1,0,0 repeating
    load(6, 16'h0300);
    mcnt = 6;
    pend = 1'b0;
    for (int c = 0; c < 18; c++) begin
      g = (c % 3 == 0);
      drive(1'b0, '0, '0, g, 1'b0, 1'b0);
      @(negedge clk);
      chk("gap_we", 32'(mem_we), 32'(pend));
      chk("gap_count", 32'(count), 32'(mcnt));
      pend = g && (mcnt > 0);
      if (pend) mcnt--;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("gap_last_we", 32'(mem_we), 32'(pend));

    // Flush with 3 words pending
    load(3, 16'h0400);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_run_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      drive(k <= 5, 16'h0444, 16'h4444, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fl%0d_we", k), 32'(mem_we), 32'(k >= 2 && k <= 4));
      chk($sformatf("fl%0d_fd", k), 32'(flush_done), 32'(k == 5));
      chk($sformatf("fl%0d_ready", k), 32'(in_ready), 32'(k == 6));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Abort with count 6 and a write in flight
    load(6, 16'h0600);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ab_pre_we", 32'(mem_we), 32'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("ab_inflight_we", 32'(mem_we), 32'd1);
    chk("ab_cycle_count", 32'(count), 32'd5);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("ab_count", 32'(count), 32'd0);
      chk("ab_we", 32'(mem_we), 32'd0);
      chk("ab_fd", 32'(flush_done), 32'd0);
    end

    // Abort and flush together
    load(2, 16'h0700);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("abfl_ready", 32'(in_ready), 32'd1);
      chk("abfl_count", 32'(count), 32'd0);
      chk("abfl_fd", 32'(flush_done), 32'd0);
    end

    // Asynchronous reset mid-stream with count 5
    load(5, 16'h0800);
    @(posedge clk);
    #1;
    mem_grant = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_we", 32'(mem_we), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    chk("mrst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("mrst_stale_we", 32'(mem_we), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
